// File: rtl/inst_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetcher_pkg
//   Shared definitions for the instruction fetcher slice: address and
//   instruction widths, boolean constants and the fetcher FSM encoding.
//   Imported by inst_fetcher and icache_dm.
// ---------------------------------------------------------------------------
package inst_fetcher_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_LOOKUP = 2'd1,
        FETCH_MEM    = 2'd2,
        FETCH_RETURN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
//   Direct-mapped instruction cache, one word per line. The read index is
//   registered when rd_en is high; hit and data are then presented
//   combinationally from the registered index during the following cycle,
//   compared against the tag supplied on rd_tag. Valid bits are cleared by
//   the asynchronous reset; tag/data storage is not reset.
//
// Ports
//   in_clk, in_rst         clock, asynchronous active-high reset
//   rd_en, rd_idx          capture a lookup index
//   rd_tag                 tag to compare against the registered line
//   rd_hit, rd_data        lookup result for the registered index
//   wr_en, wr_idx,
//   wr_tag, wr_data        line fill (sets the line valid)
// ---------------------------------------------------------------------------
module icache_dm
    import inst_fetcher_pkg::*;
#(
    parameter int ENTRIES = 256,
    parameter int IDX_W   = 8,
    parameter int TAG_W   = 22,
    parameter int DATA_W  = INSTRUCTION_WIDTH
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [DATA_W-1:0]  data_mem [ENTRIES];
    logic [IDX_W-1:0]   idx_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            if (rd_en) begin
                idx_q <= rd_idx;
            end
            if (wr_en) begin
                valid_q[wr_idx] <= TRUE;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[idx_q] && (tag_mem[idx_q] == rd_tag);
    assign rd_data = data_mem[idx_q];

endmodule

// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//   Serves one fetch request at a time from the PC controller. The request
//   is looked up in a direct-mapped icache; on a miss a single word is read
//   through mem_ctrl and written into the cache. The instruction is returned
//   to the PC controller (out_pc_last_*) and issued to the decoder
//   (out_dec_*) in the same single-cycle pulse.
//
//   Build option: define ICACHE_EN to include the icache. Without it there
//   is no array, every lookup misses and every fetch goes to mem_ctrl; ports
//   and return timing are unchanged.
//
// Ports
//   in_clk, in_rst              clock, asynchronous active-high reset
//   in_rdy                      global ready; 0 freezes all state
//   in_flush_enable             misprediction flush (highest priority)
//   in_pc_enable/_pc/_predict   fetch request from the PC controller
//   out_pc_last_enable/_pc/_inst  returned-instruction pulse to PC controller
//   out_mem_enable/_addr        word read to mem_ctrl, held until in_mem_ready
//   in_mem_ready/_data          read data from mem_ctrl (1-cycle)
//   in_dec_stall                decoder cannot accept
//   out_dec_enable/_pc/_inst/_predict  instruction issue to the decoder
//
// Timing: request sampled at edge 0; a hit returns at edge 2, a miss at
// edge 2 + memory latency (plus any cycles stalled in RETURN).
// ---------------------------------------------------------------------------
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int ICACHE_ENTRIES = 256,
    parameter int ADDR_W         = ADDRESS_WIDTH
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic                         in_rdy,
    input  logic                         in_flush_enable,
    input  logic                         in_pc_enable,
    input  logic [ADDR_W-1:0]            in_pc_pc,
    input  logic                         in_pc_predict,
    output logic                         out_pc_last_enable,
    output logic [ADDR_W-1:0]            out_pc_last_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_pc_last_inst,
    output logic                         out_mem_enable,
    output logic [ADDR_W-1:0]            out_mem_addr,
    input  logic                         in_mem_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_mem_data,
    input  logic                         in_dec_stall,
    output logic                         out_dec_enable,
    output logic [ADDR_W-1:0]            out_dec_pc,
    output logic [INSTRUCTION_WIDTH-1:0] out_dec_inst,
    output logic                         out_dec_predict
);

    localparam int INST_W = INSTRUCTION_WIDTH;

    if ((ICACHE_ENTRIES < 2) || ((ICACHE_ENTRIES & (ICACHE_ENTRIES - 1)) != 0)) begin : g_bad_entries
        $error("inst_fetcher: ICACHE_ENTRIES must be a power of two >= 2");
    end

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] req_pc_q;
    logic              req_pred_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              pend_pred_q;
    logic              pend_vld_q;
    logic              flush_drop_q;
    logic [INST_W-1:0] ret_inst_q;

    logic              req_load;
    logic [ADDR_W-1:0] req_pc_d;
    logic              req_pred_d;
    logic              mem_start;
    logic              mem_done;
    logic              drop_set;
    logic              pend_set;
    logic              hit_load;
    logic              issue_ret;
    logic              killed;

    logic              cache_hit;
    logic [INST_W-1:0] cache_data;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // The index is captured on the same edge that latches the request, so
    // the lookup result is ready in LOOKUP. Fills always use the address of
    // the outstanding read, even when that read has been flushed.
    icache_dm #(
        .ENTRIES (ICACHE_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (INST_W)
    ) u_icache (
        .in_clk  (in_clk),
        .in_rst  (in_rst),
        .rd_en   (req_load),
        .rd_idx  (req_pc_d[IDX_W+1:2]),
        .rd_tag  (req_pc_q[ADDR_W-1:IDX_W+2]),
        .rd_hit  (cache_hit),
        .rd_data (cache_data),
        .wr_en   (mem_done),
        .wr_idx  (req_pc_q[IDX_W+1:2]),
        .wr_tag  (req_pc_q[ADDR_W-1:IDX_W+2]),
        .wr_data (in_mem_data)
    );
`else
    assign cache_hit  = FALSE;
    assign cache_data = '0;
`endif

    // Outstanding read no longer belongs to a live request.
    assign killed = in_flush_enable || flush_drop_q;

    // ---- state register --------------------------------------------------
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next state and datapath strobes ---------------------------------
    always_comb begin
        state_d    = state_q;
        req_load   = FALSE;
        req_pc_d   = in_pc_pc;
        req_pred_d = in_pc_predict;
        mem_start  = FALSE;
        mem_done   = FALSE;
        drop_set   = FALSE;
        pend_set   = FALSE;
        hit_load   = FALSE;
        issue_ret  = FALSE;

        if (in_rdy) begin
            unique case (state_q)
                FETCH_IDLE: begin
                    if (in_pc_enable) begin
                        req_load = TRUE;
                        state_d  = FETCH_LOOKUP;
                    end
                end

                FETCH_LOOKUP: begin
                    if (in_flush_enable) begin
                        // A redirect arriving with the flush replaces the request.
                        req_load = in_pc_enable;
                        state_d  = in_pc_enable ? FETCH_LOOKUP : FETCH_IDLE;
                    end else if (cache_hit) begin
                        hit_load = TRUE;
                        state_d  = FETCH_RETURN;
                    end else begin
                        mem_start = TRUE;
                        state_d   = FETCH_MEM;
                    end
                end

                FETCH_MEM: begin
                    // mem_ctrl cannot be aborted: a killed read runs to completion
                    // and a redirect seen meanwhile is parked until it does.
                    pend_set = killed && in_pc_enable;
                    if (in_mem_ready) begin
                        mem_done = TRUE;
                        if (killed) begin
                            if (pend_set) begin
                                req_load = TRUE;
                                state_d  = FETCH_LOOKUP;
                            end else if (pend_vld_q) begin
                                req_load   = TRUE;
                                req_pc_d   = pend_pc_q;
                                req_pred_d = pend_pred_q;
                                state_d    = FETCH_LOOKUP;
                            end else begin
                                state_d = FETCH_IDLE;
                            end
                        end else begin
                            state_d = FETCH_RETURN;
                        end
                    end else begin
                        drop_set = in_flush_enable;
                    end
                end

                FETCH_RETURN: begin
                    if (in_flush_enable) begin
                        req_load = in_pc_enable;
                        state_d  = in_pc_enable ? FETCH_LOOKUP : FETCH_IDLE;
                    end else if (!in_dec_stall) begin
                        issue_ret = TRUE;
                        state_d   = FETCH_IDLE;
                    end
                end

                default: begin
                    state_d = FETCH_IDLE;
                end
            endcase
        end
    end

    // ---- control and output registers ------------------------------------
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            pend_vld_q         <= FALSE;
            flush_drop_q       <= FALSE;
            out_mem_enable     <= FALSE;
            out_mem_addr       <= '0;
            out_pc_last_enable <= FALSE;
            out_pc_last_pc     <= '0;
            out_pc_last_inst   <= '0;
            out_dec_enable     <= FALSE;
            out_dec_pc         <= '0;
            out_dec_inst       <= '0;
            out_dec_predict    <= FALSE;
        end else begin
            // Return strobes are single-cycle by construction; they also drop
            // while in_rdy is low because issue_ret is gated by it.
            out_pc_last_enable <= issue_ret;
            out_dec_enable     <= issue_ret;

            if (mem_done) begin
                out_mem_enable <= FALSE;
                flush_drop_q   <= FALSE;
                pend_vld_q     <= FALSE;
            end else begin
                if (drop_set) begin
                    flush_drop_q <= TRUE;
                end
                if (pend_set) begin
                    pend_vld_q <= TRUE;
                end
            end

            if (mem_start) begin
                out_mem_enable <= TRUE;
                out_mem_addr   <= req_pc_q;
            end

            if (issue_ret) begin
                out_pc_last_pc   <= req_pc_q;
                out_pc_last_inst <= ret_inst_q;
                out_dec_pc       <= req_pc_q;
                out_dec_inst     <= ret_inst_q;
                out_dec_predict  <= req_pred_q;
            end
        end
    end

    // ---- request / instruction data registers (not reset) ---------------
    always_ff @(posedge in_clk) begin
        if (req_load) begin
            req_pc_q   <= req_pc_d;
            req_pred_q <= req_pred_d;
        end
        if (pend_set && !mem_done) begin
            pend_pc_q   <= in_pc_pc;
            pend_pred_q <= in_pc_predict;
        end
        if (hit_load) begin
            ret_inst_q <= cache_data;
        end else if (mem_done) begin
            ret_inst_q <= in_mem_data;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
`timescale 1ns/1ps
module tb_inst_fetcher;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_rdy;
    logic        in_flush_enable;
    logic        in_pc_enable;
    logic [31:0] in_pc_pc;
    logic        in_pc_predict;
    logic        out_pc_last_enable;
    logic [31:0] out_pc_last_pc;
    logic [31:0] out_pc_last_inst;
    logic        out_mem_enable;
    logic [31:0] out_mem_addr;
    logic        in_mem_ready;
    logic [31:0] in_mem_data;
    logic        in_dec_stall;
    logic        out_dec_enable;
    logic [31:0] out_dec_pc;
    logic [31:0] out_dec_inst;
    logic        out_dec_predict;

`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    inst_fetcher dut (
        .in_clk             (in_clk),
        .in_rst             (in_rst),
        .in_rdy             (in_rdy),
        .in_flush_enable    (in_flush_enable),
        .in_pc_enable       (in_pc_enable),
        .in_pc_pc           (in_pc_pc),
        .in_pc_predict      (in_pc_predict),
        .out_pc_last_enable (out_pc_last_enable),
        .out_pc_last_pc     (out_pc_last_pc),
        .out_pc_last_inst   (out_pc_last_inst),
        .out_mem_enable     (out_mem_enable),
        .out_mem_addr       (out_mem_addr),
        .in_mem_ready       (in_mem_ready),
        .in_mem_data        (in_mem_data),
        .in_dec_stall       (in_dec_stall),
        .out_dec_enable     (out_dec_enable),
        .out_dec_pc         (out_dec_pc),
        .out_dec_inst       (out_dec_inst),
        .out_dec_predict    (out_dec_predict)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;
    int mem_lat = 3;

    always @(posedge in_clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h1234_5013;
    endfunction

    // mem_ctrl model: answers after mem_lat cycles of out_mem_enable
    initial begin
        int cnt;
        cnt = 0;
        in_mem_ready = 1'b0;
        in_mem_data  = 32'h0;
        forever begin
            @(negedge in_clk);
            if (in_mem_ready) begin
                in_mem_ready = 1'b0;
                cnt = 0;
            end else if (out_mem_enable) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    in_mem_ready = 1'b1;
                    in_mem_data  = mem_word(out_mem_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Output monitor
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] last_inst = 32'h0;
    logic        last_pred = 1'b0;
    int          b2b_err = 0;
    int          pair_err = 0;
    int          mem_req_cnt = 0;
    logic [31:0] last_mem_addr = 32'h0;
    logic        prev_ple = 1'b0;
    logic        prev_me = 1'b0;

    always @(negedge in_clk) begin
        if (out_pc_last_enable === 1'b1) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            last_pc   = out_pc_last_pc;
            last_inst = out_pc_last_inst;
            last_pred = out_dec_predict;
            if (prev_ple) b2b_err++;
            if (out_dec_pc !== out_pc_last_pc || out_dec_inst !== out_pc_last_inst) pair_err++;
        end
        if (out_dec_enable !== out_pc_last_enable) pair_err++;
        if (out_mem_enable === 1'b1 && !prev_me) begin
            mem_req_cnt++;
            last_mem_addr = out_mem_addr;
        end
        prev_ple = (out_pc_last_enable === 1'b1);
        prev_me  = (out_mem_enable === 1'b1);
    end

    task automatic issue(input logic [31:0] pc, input logic pred);
        @(negedge in_clk);
        in_pc_enable  = 1'b1;
        in_pc_pc      = pc;
        in_pc_predict = pred;
        @(posedge in_clk);
        #1;
        req_cyc = cyc;
        in_pc_enable = 1'b0;
    endtask

    task automatic wait_pulse(input int start);
        for (int i = 0; i < 60; i++) begin
            if (pulse_cnt != start) break;
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic wait_mem_en(input logic level);
        for (int i = 0; i < 40; i++) begin
            if (out_mem_enable === level) break;
            @(negedge in_clk);
        end
    endtask

    task automatic test_reset;
        in_rst = 1'b1;
        in_rdy = 1'b1;
        in_flush_enable = 1'b0;
        in_pc_enable = 1'b0;
        in_pc_pc = 32'h0;
        in_pc_predict = 1'b0;
        in_dec_stall = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if ({out_pc_last_enable, out_mem_enable, out_dec_enable, out_dec_predict} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {out_pc_last_enable, out_mem_enable, out_dec_enable, out_dec_predict});
        end
        checks++;
        if (out_mem_addr !== 32'h0 || out_dec_pc !== 32'h0 || out_pc_last_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: mem %h dec %h last %h want 0", out_mem_addr, out_dec_pc, out_pc_last_pc);
        end
        checks++;
        if (out_dec_inst !== 32'h0 || out_pc_last_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_inst: dec %h last %h want 0", out_dec_inst, out_pc_last_inst);
        end
        @(negedge in_clk);
        in_rst = 1'b0;
    endtask

    task automatic test_cold_miss;
        int p0, m0;
        p0 = pulse_cnt; m0 = mem_req_cnt; mem_lat = 3;
        issue(32'h0, 1'b1);
        wait_pulse(p0);
        checks++;
        if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL cold_pulse: got %0d want %0d", pulse_cnt, p0 + 1); end
        checks++;
        if (last_pc !== 32'h0 || last_inst !== 32'h0050_0093) begin
            errors++; $display("FAIL cold_data: pc %h inst %h want 00000000 00500093", last_pc, last_inst);
        end
        checks++;
        if (last_pred !== 1'b1) begin errors++; $display("FAIL cold_pred: got %b want 1", last_pred); end
        checks++;
        if (mem_req_cnt !== m0 + 1 || last_mem_addr !== 32'h0) begin
            errors++; $display("FAIL cold_mem: reqs %0d addr %h want %0d 0", mem_req_cnt - m0, last_mem_addr, 1);
        end
        checks++;
        if (pulse_cyc - req_cyc !== 5) begin errors++; $display("FAIL cold_latency: got %0d want 5", pulse_cyc - req_cyc); end
    endtask

    task automatic test_hit;
        int p0, m0, exp_lat, exp_m;
        p0 = pulse_cnt; m0 = mem_req_cnt;
        exp_lat = CACHE_ON ? 2 : 5;
        exp_m   = m0 + (CACHE_ON ? 0 : 1);
        issue(32'h0, 1'b0);
        wait_pulse(p0);
        checks++;
        if (pulse_cyc - req_cyc !== exp_lat) begin
            errors++; $display("FAIL hit_latency: got %0d want %0d", pulse_cyc - req_cyc, exp_lat);
        end
        checks++;
        if (mem_req_cnt !== exp_m) begin errors++; $display("FAIL hit_mem: got %0d want %0d", mem_req_cnt, exp_m); end
        checks++;
        if (last_inst !== 32'h0050_0093 || last_pred !== 1'b0) begin
            errors++; $display("FAIL hit_data: inst %h pred %b want 00500093 0", last_inst, last_pred);
        end
    endtask

    task automatic test_conflict;
        int p0, m0;
        p0 = pulse_cnt; m0 = mem_req_cnt;
        issue(32'h400, 1'b1);
        wait_pulse(p0);
        checks++;
        if (mem_req_cnt !== m0 + 1 || last_inst !== 32'h1234_5413 || last_pc !== 32'h400) begin
            errors++; $display("FAIL conflict_400: reqs %0d pc %h inst %h want 1 400 12345413", mem_req_cnt - m0, last_pc, last_inst);
        end
        issue(32'h0, 1'b0);
        wait_pulse(p0 + 1);
        checks++;
        if (mem_req_cnt !== m0 + 2 || last_inst !== 32'h0050_0093) begin
            errors++; $display("FAIL conflict_refetch: reqs %0d inst %h want 2 00500093", mem_req_cnt - m0, last_inst);
        end
    endtask

    task automatic test_flush_mem;
        int p0, m1;
        p0 = pulse_cnt; mem_lat = 6;
        issue(32'h8, 1'b1);
        wait_mem_en(1'b1);
        in_flush_enable = 1'b1;
        @(posedge in_clk);
        #1;
        in_flush_enable = 1'b0;
        checks++;
        if (out_mem_enable !== 1'b1 || out_mem_addr !== 32'h8) begin
            errors++; $display("FAIL flush_hold: en %b addr %h want 1 00000008", out_mem_enable, out_mem_addr);
        end
        wait_mem_en(1'b0);
        repeat (4) @(posedge in_clk);
        #1;
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL flush_nopulse: got %0d pulses want 0", pulse_cnt - p0); end
        mem_lat = 3;
        issue(32'h20, 1'b0);
        wait_pulse(p0);
        checks++;
        if (pulse_cnt !== p0 + 1 || last_pc !== 32'h20 || last_inst !== mem_word(32'h20)) begin
            errors++; $display("FAIL flush_next: pulses %0d pc %h inst %h want 1 20 %h", pulse_cnt - p0, last_pc, last_inst, mem_word(32'h20));
        end
        m1 = mem_req_cnt;
        issue(32'h8, 1'b0);
        wait_pulse(p0 + 1);
        checks++;
        if (mem_req_cnt !== m1 + (CACHE_ON ? 0 : 1) || last_inst !== mem_word(32'h8)) begin
            errors++; $display("FAIL flush_fill: reqs %0d inst %h want %0d %h", mem_req_cnt - m1, last_inst, CACHE_ON ? 0 : 1, mem_word(32'h8));
        end
    endtask

    task automatic test_stall;
        int p0, r;
        p0 = pulse_cnt;
        r = CACHE_ON ? 1 : 4;
        in_dec_stall = 1'b1;
        issue(32'h0, 1'b1);
        repeat (r + 4) @(posedge in_clk);
        #1;
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL stall_hold: got %0d pulses want 0", pulse_cnt - p0); end
        in_dec_stall = 1'b0;
        wait_pulse(p0);
        checks++;
        if (pulse_cyc - req_cyc !== r + 5) begin
            errors++; $display("FAIL stall_release: latency %0d want %0d", pulse_cyc - req_cyc, r + 5);
        end
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if (pulse_cnt !== p0 + 1 || last_pc !== 32'h0) begin
            errors++; $display("FAIL stall_once: pulses %0d pc %h want 1 0", pulse_cnt - p0, last_pc);
        end
    endtask

    task automatic test_rdy_freeze;
        int p0, base;
        p0 = pulse_cnt;
        base = CACHE_ON ? 2 : 5;
        issue(32'h0, 1'b1);
        in_rdy = 1'b0;
        repeat (5) @(posedge in_clk);
        #1;
        checks++;
        if (pulse_cnt !== p0 || out_mem_enable !== 1'b0) begin
            errors++; $display("FAIL rdy_frozen: pulses %0d mem_en %b want 0 0", pulse_cnt - p0, out_mem_enable);
        end
        in_rdy = 1'b1;
        wait_pulse(p0);
        checks++;
        if (pulse_cyc - req_cyc !== base + 5) begin
            errors++; $display("FAIL rdy_resume: latency %0d want %0d", pulse_cyc - req_cyc, base + 5);
        end
    endtask

    task automatic test_flush_redirect;
        int p0;
        p0 = pulse_cnt; mem_lat = 3;
        in_dec_stall = 1'b1;
        issue(32'h10, 1'b0);
        repeat (5) @(posedge in_clk);
        #1;
        in_flush_enable = 1'b1;
        in_pc_enable    = 1'b1;
        in_pc_pc        = 32'h24;
        in_pc_predict   = 1'b1;
        in_dec_stall    = 1'b0;
        @(posedge in_clk);
        #1;
        req_cyc = cyc;
        in_flush_enable = 1'b0;
        in_pc_enable    = 1'b0;
        wait_pulse(p0);
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if (pulse_cnt !== p0 + 1 || last_pc !== 32'h24) begin
            errors++; $display("FAIL redirect_pc: pulses %0d pc %h want 1 24", pulse_cnt - p0, last_pc);
        end
        checks++;
        if (last_inst !== mem_word(32'h24) || last_pred !== 1'b1) begin
            errors++; $display("FAIL redirect_data: inst %h pred %b want %h 1", last_inst, last_pred, mem_word(32'h24));
        end
    endtask

    task automatic test_reset_mid_mem;
        int p0, m0;
        mem_lat = 8;
        p0 = pulse_cnt;
        issue(32'h40, 1'b1);
        wait_mem_en(1'b1);
        in_rst = 1'b1;
        #1;
        checks++;
        if (out_mem_enable !== 1'b0 || out_mem_addr !== 32'h0 || out_pc_last_inst !== 32'h0 || out_dec_inst !== 32'h0) begin
            errors++; $display("FAIL rst_async: en %b addr %h inst %h/%h want 0", out_mem_enable, out_mem_addr, out_pc_last_inst, out_dec_inst);
        end
        @(posedge in_clk);
        @(negedge in_clk);
        in_rst = 1'b0;
        mem_lat = 3;
        m0 = mem_req_cnt;
        issue(32'h0, 1'b0);
        wait_pulse(p0);
        checks++;
        if (pulse_cnt !== p0 + 1 || last_pc !== 32'h0 || mem_req_cnt !== m0 + 1) begin
            errors++; $display("FAIL rst_refetch: pulses %0d pc %h reqs %0d want 1 0 1", pulse_cnt - p0, last_pc, mem_req_cnt - m0);
        end
        checks++;
        if (last_inst !== 32'h0050_0093 || pulse_cyc - req_cyc !== 5) begin
            errors++; $display("FAIL rst_refetch_data: inst %h lat %0d want 00500093 5", last_inst, pulse_cyc - req_cyc);
        end
    endtask

    task automatic test_back_to_back;
        checks++;
        if (b2b_err !== 0) begin errors++; $display("FAIL pulse_width: %0d wide pulses want 0", b2b_err); end
        checks++;
        if (pair_err !== 0) begin errors++; $display("FAIL dec_pc_pair: %0d disagreements want 0", pair_err); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_mem();
        test_stall();
        test_rdy_freeze();
        test_flush_redirect();
        test_reset_mid_mem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
